order_queue_gen: RTL and testbench
==================================

// Module: order_queue_gen
// PURPOSE
//  Parametrised successor to the game's random order source. A 32-bit Galois LFSR draws
//  multi-item customer orders, each item a (kind, count) pair with bounded values. Orders
//  are buffered in a DEPTH-entry FIFO and offered to the order/score logic over valid/ready.
//  Range reduction uses rejection sampling (no divider); LFSR is reseedable at run time.
// PARAMETERS
//  ITEMS      2             items per order
//  KIND_W     5             kind field width
//  CNT_W      7             count field width
//  NUM_KINDS  20            legal kinds 0..NUM_KINDS-1 (1..2**KIND_W)
//  MAX_CNT    99            legal counts 1..MAX_CNT (1..2**CNT_W-1)
//  DEPTH      10            FIFO entries (>=2)
//  MAX_TRIES  8             consecutive rejects before fallback value
//  SEED       32'hACE12024  reset/fallback LFSR value, must be nonzero
//  ORDER_W    derived = ITEMS*(KIND_W+CNT_W) (24 default)
// PORTS
//  clk          in   1        system clock
//  rst_n        in   1        asynchronous active-low reset
//  gen_en       in   1        allow generation of new orders
//  clear        in   1        sync flush of FIFO and in-progress order
//  seed_load    in   1        load seed_in into LFSR this cycle
//  seed_in      in   32       new seed (0 -> SEED used)
//  order_valid  out  1        FIFO head valid (count != 0)
//  order_ready  in   1        consumer pops head when valid&ready
//  order_data   out  ORDER_W  FIFO head (show-ahead)
//  pending      out  $clog2(DEPTH+1)  orders in FIFO
//  gen_busy     out  1        FSM not IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0): LFSR=SEED, state IDLE, pointers/pending=0, order_valid=0,
//   order_data=0, gen_busy=0.
//  LFSR: x^32+x^22+x^2+x+1, Galois, shifts every cycle after reset regardless of state
//   (seed_load wins that cycle). Sample r = LFSR value before the shift.
//  Packing: item i at bits [ORDER_W-1-i*(KIND_W+CNT_W) -: KIND_W+CNT_W], kind above count;
//   default = kind0[23:19] cnt0[18:12] kind1[11:7] cnt1[6:0].
//  FSM: IDLE -> DRAW_KIND when gen_en && pending<DEPTH && !clear.
//   DRAW_KIND: k=r[KIND_W-1:0]; accept if k<NUM_KINDS -> DRAW_CNT, else retry next cycle.
//   DRAW_CNT: c=r[8+CNT_W-1:8]; accept if 1<=c<=MAX_CNT -> next item DRAW_KIND,
//    or PUSH after item ITEMS-1; else retry.
//   MAX_TRIES rejects in a row on one field -> fallback kind=0 / count=1, try counter clears.
//   PUSH: write order at tail, pending+1, -> IDLE. gen_en dropping mid-order does not abort.
//  Latency, no rejects: IDLE exit to PUSH = 2*ITEMS cycles; order_valid/pending
//   visible the cycle after PUSH.
//  Full: pending==DEPTH -> FSM stays IDLE; PUSH never overflows (only producer).
//  Pop: valid&&ready -> head advances next cycle; ready with !valid ignored.
//  PUSH and pop same cycle: both occur, pending unchanged; empty FIFO pop+push illegal
//   by construction (no bypass: order_valid rises only after write).
//  Pointers wrap DEPTH-1 -> 0 (DEPTH need not be power of 2).
//  clear: pointers/pending=0, FSM IDLE, partial order dropped; LFSR unaffected; clear
//   overrides push and pop in the same cycle.
//  order_data = 0 when FIFO empty.
// TESTING
//  1 Reset: rst_n=0 mid-DRAW_CNT -> all outputs 0 immediately, LFSR=SEED after release.
//  2 gen_en=1, ready=0 -> pending climbs to 10, holds; gen_busy=0 once full; no overwrite.
//  3 Drain 1000 orders, ready=1 -> every kind<20, every count 1..99; matches C LFSR model.
//  4 seed_load=1 seed_in=0 -> identical order stream as after reset; seed_in=1 -> model.
//  5 NUM_KINDS=1,MAX_CNT=1 -> every order 24'h001001 (kind 0/count 1, fallback or not).
//  6 clear during DRAW and PUSH with pop -> pending=0, order_valid=0 next cycle, no ghost.

Source files
------------

// File: rtl/order_queue_gen.sv
// ============================================================================
// order_queue_gen
// ----------------------------------------------------------------------------
// Random customer-order source. A free-running 32-bit Galois LFSR is sampled
// by a small draw FSM. The FSM builds an order of ITEMS (kind, count) pairs
// and pushes the finished order into a DEPTH-entry FIFO. The consumer reads
// the FIFO over a valid/ready handshake.
//
// Range reduction uses rejection sampling: out-of-range draws are retried on
// the next LFSR value. After MAX_TRIES consecutive rejects the field falls
// back to kind 0 or count 1.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   gen_en       allow the FSM to start a new order
//   clear        synchronous flush of the FIFO and of any partial order
//   seed_load    load seed_in into the LFSR this cycle (zero selects SEED)
//   seed_in      run-time seed
//   order_valid  FIFO head is valid
//   order_ready  consumer accepts the head when order_valid is high
//   order_data   FIFO head, show-ahead; zero when the FIFO is empty
//   pending      number of orders held in the FIFO
//   gen_busy     draw FSM is not idle
// ============================================================================
module order_queue_gen #(
    parameter int          ITEMS     = 2,
    parameter int          KIND_W    = 5,
    parameter int          CNT_W     = 7,
    parameter int          NUM_KINDS = 20,
    parameter int          MAX_CNT   = 99,
    parameter int          DEPTH     = 10,
    parameter int          MAX_TRIES = 8,
    parameter logic [31:0] SEED      = 32'hACE12024,
    localparam int         ORDER_W   = ITEMS * (KIND_W + CNT_W),
    localparam int         PEND_W    = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               gen_en,
    input  logic               clear,
    input  logic               seed_load,
    input  logic [31:0]        seed_in,
    output logic               order_valid,
    input  logic               order_ready,
    output logic [ORDER_W-1:0] order_data,
    output logic [PEND_W-1:0]  pending,
    output logic               gen_busy
);

    localparam int FIELD_W = KIND_W + CNT_W;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ITEM_W  = $clog2(ITEMS + 1);
    localparam int TRY_W   = $clog2(MAX_TRIES + 1);

    // Feedback mask for x^32 + x^22 + x^2 + x + 1 in right-shifting form.
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    localparam logic [KIND_W:0]   KIND_LIMIT = (KIND_W + 1)'(NUM_KINDS);
    localparam logic [CNT_W-1:0]  CNT_LIMIT  = CNT_W'(MAX_CNT);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [TRY_W-1:0]  LAST_TRY   = TRY_W'(MAX_TRIES - 1);
    localparam logic [ITEM_W-1:0] LAST_ITEM  = ITEM_W'(ITEMS - 1);
    localparam logic [PTR_W-1:0]  LAST_PTR   = PTR_W'(DEPTH - 1);
    localparam logic [PEND_W-1:0] FULL_CNT   = PEND_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DRAW_KIND = 2'd1,
        DRAW_CNT  = 2'd2,
        PUSH      = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [31:0]         lfsr_q, lfsr_d;
    logic [ITEM_W-1:0]   item_q, item_d;
    logic [TRY_W-1:0]    tries_q, tries_d;
    logic [ORDER_W-1:0]  order_q, order_d;
    logic [ORDER_W-1:0]  mem_q [DEPTH];
    logic [ORDER_W-1:0]  mem_d [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PEND_W-1:0]   count_q, count_d;

    logic                push;
    logic                pop;
    logic [KIND_W-1:0]   kind_draw;
    logic [CNT_W-1:0]    cnt_draw;
    logic                kind_ok;
    logic                cnt_ok;
    logic                give_up;

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return {1'b0, v[31:1]} ^ (v[0] ? LFSR_TAPS : 32'h0);
    endfunction

    // The LFSR advances every cycle whatever the FSM is doing, so the stream
    // position depends only on time since reset or the last seed load.
    always_comb begin
        lfsr_d = lfsr_step(lfsr_q);
        if (seed_load) begin
            lfsr_d = (seed_in == 32'h0) ? SEED : seed_in;
        end
    end

    // Both fields are drawn from the current (pre-shift) LFSR value.
    always_comb begin
        kind_draw = lfsr_q[KIND_W-1:0];
        cnt_draw  = lfsr_q[8 +: CNT_W];
        kind_ok   = {1'b0, kind_draw} < KIND_LIMIT;
        cnt_ok    = (cnt_draw >= CNT_ONE) && (cnt_draw <= CNT_LIMIT);
        give_up   = (tries_q == LAST_TRY);
    end

    // Draw FSM. A field is retried on the next cycle until accepted or until
    // the reject budget runs out, which substitutes the fallback value.
    // gen_en is only looked at in IDLE, so a started order always completes
    // unless clear drops it.
    always_comb begin
        state_d = state_q;
        item_d  = item_q;
        tries_d = tries_q;
        order_d = order_q;
        push    = 1'b0;

        case (state_q)
            IDLE: begin
                if (gen_en && (count_q < FULL_CNT) && !clear) begin
                    state_d = DRAW_KIND;
                    item_d  = '0;
                    tries_d = '0;
                end
            end

            DRAW_KIND: begin
                if (kind_ok || give_up) begin
                    for (int i = 0; i < ITEMS; i++) begin
                        if (item_q == ITEM_W'(i)) begin
                            order_d[ORDER_W-1-i*FIELD_W -: KIND_W] =
                                kind_ok ? kind_draw : '0;
                        end
                    end
                    tries_d = '0;
                    state_d = DRAW_CNT;
                end else begin
                    tries_d = tries_q + 1'b1;
                end
            end

            DRAW_CNT: begin
                if (cnt_ok || give_up) begin
                    for (int i = 0; i < ITEMS; i++) begin
                        if (item_q == ITEM_W'(i)) begin
                            order_d[ORDER_W-1-i*FIELD_W-KIND_W -: CNT_W] =
                                cnt_ok ? cnt_draw : CNT_ONE;
                        end
                    end
                    tries_d = '0;
                    if (item_q == LAST_ITEM) begin
                        state_d = PUSH;
                    end else begin
                        item_d  = item_q + 1'b1;
                        state_d = DRAW_KIND;
                    end
                end else begin
                    tries_d = tries_q + 1'b1;
                end
            end

            PUSH: begin
                push    = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // A flush abandons whatever order is being assembled.
        if (clear) begin
            state_d = IDLE;
            item_d  = '0;
            tries_d = '0;
            order_d = '0;
            push    = 1'b0;
        end
    end

    // FIFO bookkeeping. The FSM only enters a draw when there is space, so
    // push never overflows. Pop requires a valid head, and the head only
    // becomes valid after the write, so an empty FIFO cannot pop and push
    // in the same cycle.
    always_comb begin
        pop      = (count_q != '0) && order_ready;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = order_q;
                wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            lfsr_q   <= SEED;
            item_q   <= '0;
            tries_q  <= '0;
            order_q  <= '0;
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            item_q   <= item_d;
            tries_q  <= tries_d;
            order_q  <= order_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Stale entries stay in memory after a pop or flush, so the head is
    // masked to zero whenever the FIFO is empty.
    always_comb begin
        order_valid = (count_q != '0);
        order_data  = order_valid ? mem_q[rd_ptr_q] : '0;
        pending     = count_q;
        gen_busy    = (state_q != IDLE);
    end

endmodule

// File: tb/tb_order_queue_gen.sv
// ============================================================================
// tb_order_queue_gen
// ----------------------------------------------------------------------------
// Directed bench for order_queue_gen. A reference LFSR walks the same stream
// as the DUT and a software draw routine turns it into the expected order
// sequence. A second instance with one legal kind and one legal count must
// only ever produce 24'h001001.
// ============================================================================
module tb_order_queue_gen;

    localparam logic [31:0] SEED = 32'hACE12024;

    logic        clk;
    logic        rst_n;
    logic        genEn;
    logic        clear;
    logic        seedLoad;
    logic [31:0] seedIn;
    logic        orderReady;
    logic        orderValid;
    logic [23:0] orderData;
    logic [3:0]  pending;
    logic        genBusy;

    logic        fbReady;
    logic        fbValid;
    logic [23:0] fbData;
    logic [3:0]  fbPending;
    logic        fbBusy;

    int          checks;
    int          passes;
    int          popCount;
    int          fbChecks;
    bit          monOn;
    logic [31:0] mLfsr;

    order_queue_gen dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .gen_en      (genEn),
        .clear       (clear),
        .seed_load   (seedLoad),
        .seed_in     (seedIn),
        .order_valid (orderValid),
        .order_ready (orderReady),
        .order_data  (orderData),
        .pending     (pending),
        .gen_busy    (genBusy)
    );

    order_queue_gen #(.NUM_KINDS(1), .MAX_CNT(1)) dutFb (
        .clk         (clk),
        .rst_n       (rst_n),
        .gen_en      (genEn),
        .clear       (clear),
        .seed_load   (seedLoad),
        .seed_in     (seedIn),
        .order_valid (fbValid),
        .order_ready (fbReady),
        .order_data  (fbData),
        .pending     (fbPending),
        .gen_busy    (fbBusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every comparison in the bench is routed through here.
    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        if (obs === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive all inputs just after a rising edge.
    task automatic applyStimulus(input bit gen, input bit rdy, input bit clr,
                                 input bit sld, input logic [31:0] sin);
        @(posedge clk);
        #1;
        genEn      = gen;
        orderReady = rdy;
        clear      = clr;
        seedLoad   = sld;
        seedIn     = sin;
    endtask

    function automatic logic [31:0] lfsrStep(input logic [31:0] v);
        logic [31:0] n;
        n = v >> 1;
        if (v[0]) n = n ^ 32'h8020_0003;
        return n;
    endfunction

    // Reference draw: mLfsr holds the value seen in the idle cycle that
    // launches the order; on return it holds the value of the next idle
    // cycle. The push cycle consumes one value between orders.
    task automatic modelOrder(output logic [23:0] o);
        logic [4:0] k;
        logic [6:0] c;
        int         tries;
        o = '0;
        mLfsr = lfsrStep(mLfsr);
        for (int item = 0; item < 2; item++) begin
            tries = 0;
            while (1) begin
                k = mLfsr[4:0];
                mLfsr = lfsrStep(mLfsr);
                if (k < 5'd20) break;
                tries++;
                if (tries == 8) begin
                    k = 5'd0;
                    break;
                end
            end
            tries = 0;
            while (1) begin
                c = mLfsr[14:8];
                mLfsr = lfsrStep(mLfsr);
                if (c >= 7'd1 && c <= 7'd99) break;
                tries++;
                if (tries == 8) begin
                    c = 7'd1;
                    break;
                end
            end
            o[23 - 12*item -: 12] = {k, c};
        end
        mLfsr = lfsrStep(mLfsr);
    endtask

    // Checks every accepted order against the reference stream and bounds.
    always @(negedge clk) begin
        logic [23:0] exp;
        if (monOn && rst_n && !clear && orderValid && orderReady) begin
            modelOrder(exp);
            checkOutput("order_data", {8'h0, orderData}, {8'h0, exp});
            checkOutput("kind0_range", {31'h0, orderData[23:19] < 5'd20}, 32'h1);
            checkOutput("kind1_range", {31'h0, orderData[11:7] < 5'd20}, 32'h1);
            checkOutput("cnt0_range",
                {31'h0, orderData[18:12] >= 7'd1 && orderData[18:12] <= 7'd99}, 32'h1);
            checkOutput("cnt1_range",
                {31'h0, orderData[6:0] >= 7'd1 && orderData[6:0] <= 7'd99}, 32'h1);
            popCount++;
        end
        if (rst_n && !clear && fbValid && fbChecks < 100) begin
            checkOutput("fallback_order", {8'h0, fbData}, 32'h0000_1001);
            fbChecks++;
        end
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks     = 0;
        passes     = 0;
        popCount   = 0;
        fbChecks   = 0;
        monOn      = 1'b0;
        mLfsr      = SEED;
        fbReady    = 1'b1;
        rst_n      = 1'b0;
        genEn      = 1'b0;
        clear      = 1'b0;
        seedLoad   = 1'b0;
        seedIn     = 32'h0;
        orderReady = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        checkOutput("rst_valid", {31'h0, orderValid}, 32'h0);
        checkOutput("rst_pending", {28'h0, pending}, 32'h0);
        checkOutput("rst_busy", {31'h0, genBusy}, 32'h0);
        checkOutput("rst_data", {8'h0, orderData}, 32'h0);

        // Fill: generator stalls at DEPTH with nothing consumed.
        genEn = 1'b1;
        mLfsr = SEED;
        monOn = 1'b1;
        #2 rst_n = 1'b1;
        for (int i = 0; i < 400 && pending != 4'd10; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        checkOutput("full_pending", {28'h0, pending}, 32'd10);
        checkOutput("full_busy", {31'h0, genBusy}, 32'h0);
        checkOutput("full_valid", {31'h0, orderValid}, 32'h1);
        repeat (20) @(negedge clk);
        checkOutput("full_hold", {28'h0, pending}, 32'd10);

        // Drain the ten stored orders; contents prove nothing was overwritten.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 50 && pending != 4'd0; i++) @(negedge clk);
        @(negedge clk);
        checkOutput("drain_pops", popCount, 32'd10);
        checkOutput("drain_valid", {31'h0, orderValid}, 32'h0);
        checkOutput("drain_data", {8'h0, orderData}, 32'h0);
        checkOutput("drain_pending", {28'h0, pending}, 32'h0);

        // Asynchronous reset in the middle of an order.
        monOn = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 200 && !(pending >= 4'd2 && genBusy); i++) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_valid", {31'h0, orderValid}, 32'h0);
        checkOutput("async_pending", {28'h0, pending}, 32'h0);
        checkOutput("async_busy", {31'h0, genBusy}, 32'h0);
        checkOutput("async_data", {8'h0, orderData}, 32'h0);

        // Long drain from the reset seed.
        mLfsr      = SEED;
        popCount   = 0;
        orderReady = 1'b1;
        genEn      = 1'b1;
        monOn      = 1'b1;
        #3 rst_n = 1'b1;
        for (int i = 0; i < 40000 && popCount < 1000; i++) @(negedge clk);
        checkOutput("stream_1000", {31'h0, popCount >= 1000}, 32'h1);

        // Reseed with zero: stream restarts exactly as after reset.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        mLfsr    = SEED;
        popCount = 0;
        for (int i = 0; i < 3000 && popCount < 50; i++) @(negedge clk);
        checkOutput("reseed0_pops", {31'h0, popCount >= 50}, 32'h1);

        // Reseed with one.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        mLfsr    = 32'h1;
        popCount = 0;
        for (int i = 0; i < 3000 && popCount < 50; i++) @(negedge clk);
        checkOutput("reseed1_pops", {31'h0, popCount >= 50}, 32'h1);

        // Clear at a sweep of points across draw and push, with a pop request.
        monOn = 1'b0;
        for (int d = 0; d < 12; d++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'h0);
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
            repeat (14 + d) @(posedge clk);
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
            @(negedge clk);
            checkOutput("clr_pending", {28'h0, pending}, 32'h0);
            checkOutput("clr_valid", {31'h0, orderValid}, 32'h0);
            checkOutput("clr_busy", {31'h0, genBusy}, 32'h0);
            checkOutput("clr_data", {8'h0, orderData}, 32'h0);
            repeat (10) @(negedge clk);
            checkOutput("clr_noghost", {27'h0, orderValid, pending}, 32'h0);
        end

        checkOutput("fallback_seen", {31'h0, fbChecks >= 20}, 32'h1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
